// File: rtl/mbadd_pkg.sv
// Shared definitions for the byte-serial multi-precision adder sequencer.
package mbadd_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/multibyte_add_seq_if.sv
// Request/result bundle between a control unit and multibyte_add_seq.
// The sub request line exists only when MBADD_SUB_EN is defined.
interface multibyte_add_seq_if #(parameter int NBYTES = 4);
  import mbadd_pkg::*;

  logic                     start;
  logic [BYTE_W*NBYTES-1:0] a;
  logic [BYTE_W*NBYTES-1:0] b;
  logic                     cin;
`ifdef MBADD_SUB_EN
  logic                     sub;
`endif
  logic                     ready;
  logic                     done;
  logic [BYTE_W*NBYTES-1:0] sum;
  logic                     cout;
  logic                     ovf;

`ifdef MBADD_SUB_EN
  modport master (output start, a, b, cin, sub, input ready, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output ready, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input ready, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output ready, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/multibyte_add_seq_adder8_cla.sv
// Combinational 8-bit propagate/generate carry-chain adder shared by the sequencer.
module adder8_cla
  import mbadd_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic [BYTE_W-1:0] p_s;
  logic [BYTE_W-1:0] g_s;
  logic              c_s;

  // Ripple the carry through per-bit propagate/generate terms.
  always_comb begin
    p_s = a ^ b;
    g_s = a & b;
    c_s = ci;
    s   = {BYTE_W{1'b0}};
    for (int i = 0; i < BYTE_W; i++) begin
      s[i] = p_s[i] ^ c_s;
      c_s  = g_s[i] | (p_s[i] & c_s);
    end
    co = c_s;
  end

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-precision adder: one shared 8-bit adder, LSB byte first.
// Defining MBADD_SUB_EN adds the sub request (A - B via inverted B and carry-in 1).
module multibyte_add_seq
  import mbadd_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input logic                clk,
  input logic                rst_n,
  multibyte_add_seq_if.slave bus
);

  localparam int                W        = BYTE_W * NBYTES;
  localparam int                IDX_W    = $clog2(NBYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

  state_e             state_r;
  logic [W-1:0]       a_sh_r;
  logic [W-1:0]       b_sh_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic [W-1:0]       sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               done_r;
  logic               ready_r;
  logic               a_msb_r;
  logic               b_msb_r;

  logic [W-1:0]       b_eff_s;
  logic               cin_eff_s;
  logic [BYTE_W-1:0]  add_s;
  logic               co_s;

  // Effective B operand and carry-in for the request being accepted.
  always_comb begin
`ifdef MBADD_SUB_EN
    if (bus.sub) begin
      b_eff_s   = ~bus.b;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = bus.b;
      cin_eff_s = bus.cin;
    end
`else
    b_eff_s   = bus.b;
    cin_eff_s = bus.cin;
`endif
  end

  adder8_cla u_adder (
    .a  (a_sh_r[BYTE_W-1:0]),
    .b  (b_sh_r[BYTE_W-1:0]),
    .ci (carry_r),
    .s  (add_s),
    .co (co_s)
  );

  // Sequencer FSM; operand msbs are kept aside because the shifters consume them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sh_r  <= {W{1'b0}};
      b_sh_r  <= {W{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= b_eff_s;
            carry_r <= cin_eff_s;
            idx_r   <= {IDX_W{1'b0}};
            sum_r   <= {W{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            a_msb_r <= bus.a[W-1];
            b_msb_r <= b_eff_s[W-1];
            ready_r <= 1'b0;
            state_r <= RUN;
          end
        end
        RUN: begin
          sum_r[int'(idx_r)*BYTE_W +: BYTE_W] <= add_s;
          carry_r <= co_s;
          idx_r   <= idx_r + IDX_W'(1);
          a_sh_r  <= {{BYTE_W{1'b0}}, a_sh_r[W-1:BYTE_W]};
          b_sh_r  <= {{BYTE_W{1'b0}}, b_sh_r[W-1:BYTE_W]};
          if (idx_r == LAST_IDX) begin
            cout_r  <= co_s;
            ovf_r   <= (a_msb_r == b_msb_r) && (add_s[BYTE_W-1] != a_msb_r);
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_r;
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.cout  = cout_r;
  assign bus.ovf   = ovf_r;

endmodule
